// File: rtl/fetch_ctrl_pkg.sv
// Shared state codes, opcode constants and response codes for the fetch stage.
package fetch_ctrl_pkg;

  // The PC register decodes WAIT_READY (001) and WAIT_BRANCH (100) directly.
  typedef enum logic [2:0] {
    FC_IDLE        = 3'b000,
    FC_WAIT_READY  = 3'b001,
    FC_DATA        = 3'b010,
    FC_ADDR        = 3'b110,
    FC_WAIT_BRANCH = 3'b100,
    FC_ERR         = 3'b101,
    FC_HALT        = 3'b111
  } fc_state_t;

  localparam logic [6:0]  OP_JAL      = 7'b1101111;
  localparam logic [6:0]  OP_JALR     = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read handshake plus the valid/ready link to decode.
interface fetch_ctrl_if;
  logic       arvalid_o;
  logic       arready_i;
  logic       rvalid_i;
  logic [1:0] rresp_i;
  logic       rready_o;
  logic       valid_o;
  logic       ready_i;

  modport master (
    output arvalid_o, rready_o, valid_o,
    input  arready_i, rvalid_i, rresp_i, ready_i
  );

  modport slave (
    input  arvalid_o, rready_o, valid_o,
    output arready_i, rvalid_i, rresp_i, ready_i
  );
endinterface

// File: rtl/fetch_ctrl_predecode.sv
// Combinational predecode of the latched instruction: control flow and ebreak.
module fetch_predecode
  import fetch_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        is_ctrl,
  output logic        is_ebreak
);

  logic [6:0] opcode;

  assign opcode    = inst_i[6:0];
  assign is_ctrl   = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
  assign is_ebreak = (inst_i == INST_EBREAK);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: memory read handshake, decode handoff, branch stall,
// sticky halt/error and saturating fetch/stall counters.
//
// state       | meaning
// IDLE        | waiting for start_i
// ADDR        | read address offered to memory
// DATA        | waiting for read data
// WAIT_READY  | instruction offered to decode
// WAIT_BRANCH | control-flow instruction waiting on execute
// ERR         | memory fault or timeout, terminal
// HALT        | ebreak retired, terminal
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  output logic             firing_o,
  output logic [2:0]       state_o,
  output logic             pc_we_o,
  output logic             inst_we_o,
  input  logic [31:0]      inst_i,
  fetch_ctrl_if.master     bus,
  input  logic             branch_valid_i,
  output logic             halt_o,
  output logic             err_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  fc_state_t       state_q, state_d;
  logic [TO_W-1:0] to_cnt;
  logic            to_clr, to_hit;
  logic            fetch_inc, stall_inc;
  logic            is_ctrl, is_ebreak;

  fetch_predecode u_predecode (
    .inst_i    (inst_i),
    .is_ctrl   (is_ctrl),
    .is_ebreak (is_ebreak)
  );

  // >= rather than == so a fetch that spent its whole budget in ADDR still times out in DATA.
  assign to_hit  = (to_cnt >= TO_W'(TIMEOUT - 1));
  assign state_o = state_q;
  assign halt_o  = (state_q == FC_HALT);
  assign err_o   = (state_q == FC_ERR);

  always_comb begin
    state_d       = state_q;
    firing_o      = 1'b0;
    pc_we_o       = 1'b0;
    inst_we_o     = 1'b0;
    bus.arvalid_o = 1'b0;
    bus.rready_o  = 1'b0;
    bus.valid_o   = 1'b0;
    fetch_inc     = 1'b0;
    stall_inc     = 1'b0;
    to_clr        = 1'b0;
    case (state_q)
      FC_IDLE: begin
        if (start_i) begin
          firing_o = 1'b1;
          to_clr   = 1'b1;
          state_d  = FC_ADDR;
        end
      end
      FC_ADDR: begin
        bus.arvalid_o = 1'b1;
        if (bus.arready_i)  state_d = FC_DATA;
        else if (to_hit)    state_d = FC_ERR;
      end
      FC_DATA: begin
        bus.rready_o = 1'b1;
        if (bus.rvalid_i) begin
          if (bus.rresp_i == RESP_OKAY) begin
            inst_we_o = 1'b1;
            fetch_inc = 1'b1;
            state_d   = FC_WAIT_READY;
          end else begin
            state_d   = FC_ERR;
          end
        end else if (to_hit) begin
          state_d = FC_ERR;
        end
      end
      FC_WAIT_READY: begin
        bus.valid_o = 1'b1;
        if (!bus.ready_i) begin
          stall_inc = 1'b1;
        end else if (is_ebreak) begin
          state_d = FC_HALT;
        end else if (is_ctrl) begin
          state_d = FC_WAIT_BRANCH;
        end else begin
          pc_we_o = 1'b1;
          to_clr  = 1'b1;
          state_d = FC_ADDR;
        end
      end
      FC_WAIT_BRANCH: begin
        if (!branch_valid_i) begin
          stall_inc = 1'b1;
        end else begin
          to_clr  = 1'b1;
          state_d = FC_ADDR;
        end
      end
      FC_ERR:  state_d = FC_ERR;
      FC_HALT: state_d = FC_HALT;
      default: state_d = FC_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FC_IDLE;
      to_cnt      <= '0;
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (to_clr)
        to_cnt <= '0;
      else if (state_q == FC_ADDR || state_q == FC_DATA)
        to_cnt <= to_cnt + 1'b1;
      if (fetch_inc && fetch_cnt_o != '1)
        fetch_cnt_o <= fetch_cnt_o + 1'b1;
      if (stall_inc && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: instruction scoreboard, state sequencing,
// stalls, timeout boundary, memory error, halt and asynchronous reset.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int CW  = 4;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          bv    = 1'b0;
  logic          firing, pc_we, inst_we, halt, err;
  logic [2:0]    state;
  logic [CW-1:0] fcnt, scnt;
  logic [31:0]   inst_reg;
  logic [31:0]   rdata = '0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_f   = 0;
  int          exp_s   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_ins;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.TIMEOUT(TO), .TO_W(8), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_i        (start),
    .firing_o       (firing),
    .state_o        (state),
    .pc_we_o        (pc_we),
    .inst_we_o      (inst_we),
    .inst_i         (inst_reg),
    .bus            (bus.master),
    .branch_valid_i (bv),
    .halt_o         (halt),
    .err_o          (err),
    .fetch_cnt_o    (fcnt),
    .stall_cnt_o    (scnt)
  );

  always #5 clock = ~clock;

  // Instruction register of the datapath, fed back as inst_i.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       inst_reg <= '0;
    else if (inst_we) inst_reg <= rdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    #1;
    check("idle_state", state, 3'b000);
    check("firing_hi", firing, 1'b1);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("firing_lo", firing, 1'b0);
    check("addr_state", state, 3'b110);
  endtask

  // Entered and left at negedge+1; on return the instruction is being accepted by decode.
  task automatic fetch_one(input logic [31:0] ins, input int rdy_wait);
    bus.arready_i = 1'b1;
    #1;
    check("arvalid", bus.arvalid_o, 1'b1);
    @(negedge clock);
    bus.arready_i = 1'b0;
    bus.rvalid_i  = 1'b1;
    bus.rresp_i   = 2'b00;
    rdata         = ins;
    #1;
    check("data_state", state, 3'b010);
    check("rready", bus.rready_o, 1'b1);
    check("inst_we", inst_we, 1'b1);
    sb.push_back(ins);
    exp_f = sat_inc(exp_f);
    @(negedge clock);
    bus.rvalid_i = 1'b0;
    for (int i = 0; i < rdy_wait; i++) begin
      bus.ready_i = 1'b0;
      #1;
      check("stall_state", state, 3'b001);
      check("stall_valid", bus.valid_o, 1'b1);
      check("stall_pc_we", pc_we, 1'b0);
      exp_s = sat_inc(exp_s);
      @(negedge clock);
    end
    bus.ready_i = 1'b1;
    #1;
    check("wr_state", state, 3'b001);
    check("wr_valid", bus.valid_o, 1'b1);
    exp_ins = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check("inst", inst_reg, exp_ins);
  endtask

  task automatic to_addr_after_accept();
    @(negedge clock);
    bus.ready_i = 1'b0;
    #1;
    check("next_addr", state, 3'b110);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_state", state, 3'b000);
    check("rst_err", err, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_fcnt", fcnt, '0);
    check("rst_scnt", scnt, '0);
    exp_f = 0;
    exp_s = 0;
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  always @(negedge clock) begin
    #2;
    if (reset) check("one_hot_we", ($countones({firing, pc_we, inst_we}) <= 1), 1'b1);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] tbl_ins  [6] = '{32'h0000_8067, 32'h0000_0463, 32'h0000_0033,
                                32'h0000_0073, 32'h0020_0073, 32'h0000_006B};
  logic        tbl_ctrl [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    bus.arready_i = 1'b0;
    bus.rvalid_i  = 1'b0;
    bus.rresp_i   = 2'b00;
    bus.ready_i   = 1'b0;
    #1;
    check("r_state", state, 3'b000);
    check("r_firing", firing, 1'b0);
    check("r_arvalid", bus.arvalid_o, 1'b0);
    check("r_rready", bus.rready_o, 1'b0);
    check("r_valid", bus.valid_o, 1'b0);
    check("r_pc_we", pc_we, 1'b0);
    check("r_inst_we", inst_we, 1'b0);
    check("r_halt", halt, 1'b0);
    check("r_err", err, 1'b0);
    check("r_fcnt", fcnt, '0);
    check("r_scnt", scnt, '0);
    @(negedge clock);
    reset = 1'b1;
    #1;

    // Zero-wait fetch of a nop.
    do_start();
    fetch_one(32'h0000_0013, 0);
    check("nop_pc_we", pc_we, 1'b1);
    to_addr_after_accept();
    check("fcnt_1", fcnt, exp_f);

    // Decode back-pressure.
    fetch_one(32'h0000_0013, 5);
    check("bp_pc_we", pc_we, 1'b1);
    to_addr_after_accept();
    check("scnt_5", scnt, exp_s);

    // jal waits for execute.
    fetch_one(32'h0000_006F, 0);
    check("jal_pc_we", pc_we, 1'b0);
    @(negedge clock);
    bus.ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("wb_state", state, 3'b100);
      check("wb_pc_we", pc_we, 1'b0);
      exp_s = sat_inc(exp_s);
      @(negedge clock);
      #1;
    end
    bv = 1'b1;
    #1;
    check("wb_state_last", state, 3'b100);
    check("wb_pc_we_last", pc_we, 1'b0);
    @(negedge clock);
    bv = 1'b0;
    #1;
    check("wb_to_addr", state, 3'b110);
    check("scnt_jal", scnt, exp_s);

    // Other control-flow opcodes and lookalikes.
    for (int k = 0; k < 6; k++) begin
      fetch_one(tbl_ins[k], 0);
      check("tbl_pc_we", pc_we, !tbl_ctrl[k]);
      @(negedge clock);
      bus.ready_i = 1'b0;
      #1;
      if (tbl_ctrl[k]) begin
        check("tbl_wb", state, 3'b100);
        bv = 1'b1;
        @(negedge clock);
        bv = 1'b0;
        #1;
      end
      check("tbl_addr", state, 3'b110);
    end
    check("fcnt_tbl", fcnt, exp_f);

    // Stall counter saturation.
    fetch_one(32'h0000_0013, 12);
    check("sat_pc_we", pc_we, 1'b1);
    to_addr_after_accept();
    check("scnt_sat", scnt, exp_s);

    // Completion on the last allowed cycle wins over the timeout.
    bus.arready_i = 1'b0;
    @(negedge clock);
    #1;
    check("tb_addr2", state, 3'b110);
    bus.arready_i = 1'b1;
    @(negedge clock);
    bus.arready_i = 1'b0;
    #1;
    check("tb_data1", state, 3'b010);
    @(negedge clock);
    bus.rvalid_i = 1'b1;
    rdata        = 32'h0000_0013;
    #1;
    check("tb_inst_we", inst_we, 1'b1);
    sb.push_back(rdata);
    exp_f = sat_inc(exp_f);
    @(negedge clock);
    bus.rvalid_i = 1'b0;
    bus.ready_i  = 1'b1;
    #1;
    check("tb_wr", state, 3'b001);
    check("tb_err", err, 1'b0);
    exp_ins = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check("tb_inst", inst_reg, exp_ins);
    to_addr_after_accept();
    check("tb_fcnt", fcnt, exp_f);

    // Timeout while waiting for read data.
    bus.arready_i = 1'b1;
    @(negedge clock);
    bus.arready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dto_state", state, 3'b010);
      check("dto_err", err, 1'b0);
      @(negedge clock);
    end
    #1;
    check("dto_err_state", state, 3'b101);
    check("dto_err_hi", err, 1'b1);
    do_reset();

    // ebreak halts; start ignored afterwards.
    do_start();
    fetch_one(32'h0010_0073, 0);
    check("eb_pc_we", pc_we, 1'b0);
    @(negedge clock);
    bus.ready_i = 1'b0;
    #1;
    check("halt_state", state, 3'b111);
    check("halt_hi", halt, 1'b1);
    check("halt_valid", bus.valid_o, 1'b0);
    start = 1'b1;
    #1;
    check("halt_firing", firing, 1'b0);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("halt_stay", state, 3'b111);
    do_reset();

    // Asynchronous reset in the middle of DATA; late rvalid ignored.
    do_start();
    bus.arready_i = 1'b1;
    @(negedge clock);
    bus.arready_i = 1'b0;
    #1;
    check("ar_data", state, 3'b010);
    #2;
    reset = 1'b0;
    #1;
    check("ar_state", state, 3'b000);
    check("ar_rready", bus.rready_o, 1'b0);
    check("ar_arvalid", bus.arvalid_o, 1'b0);
    check("ar_valid", bus.valid_o, 1'b0);
    check("ar_fcnt", fcnt, '0);
    exp_f = 0;
    exp_s = 0;
    @(negedge clock);
    reset        = 1'b1;
    bus.rvalid_i = 1'b1;
    rdata        = 32'h0000_0013;
    #1;
    check("late_inst_we", inst_we, 1'b0);
    @(negedge clock);
    bus.rvalid_i = 1'b0;
    #1;
    check("late_state", state, 3'b000);
    check("late_fcnt", fcnt, exp_f);

    // Error response.
    do_start();
    bus.arready_i = 1'b1;
    @(negedge clock);
    bus.arready_i = 1'b0;
    bus.rvalid_i  = 1'b1;
    bus.rresp_i   = 2'b10;
    #1;
    check("slv_inst_we", inst_we, 1'b0);
    check("slv_data", state, 3'b010);
    @(negedge clock);
    bus.rvalid_i = 1'b0;
    bus.rresp_i  = 2'b00;
    #1;
    check("slv_err_state", state, 3'b101);
    check("slv_err", err, 1'b1);
    check("slv_fcnt", fcnt, '0);
    start = 1'b1;
    #1;
    check("slv_firing", firing, 1'b0);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("slv_stay", state, 3'b101);
    do_reset();

    // arready never comes: four cycles in ADDR then ERR.
    do_start();
    for (int i = 0; i < TO; i++) begin
      check("ato_state", state, 3'b110);
      check("ato_arvalid", bus.arvalid_o, 1'b1);
      check("ato_err", err, 1'b0);
      @(negedge clock);
      #1;
    end
    check("ato_err_state", state, 3'b101);
    check("ato_err_hi", err, 1'b1);
    start = 1'b1;
    #1;
    check("ato_firing", firing, 1'b0);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("ato_stay", state, 3'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing FSM for the fetch stage. Drives the fetch PC/instruction register's `firing`, `state`, `pc_we` and `inst_we` controls.
- Runs the read-address/read-data handshake to instruction memory.
- Presents the fetched instruction to decode with a valid/ready handshake.
- Stalls on control-flow instructions until execute resolves them. Halts on ebreak. Latches a sticky error on memory faults or timeouts.
- Also provides saturating fetch and stall performance counters.

Parameters:
- TIMEOUT, 255: maximum cycles spent in ADDR+DATA for one fetch before error; 1..2^TO_W-1.
- TO_W, 8: timeout counter width.
- CNT_W, 32: width of each performance counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; honoured only in IDLE.
- firing_o  out  1  load RESET_VECTOR into PC this edge; combinational = (state==IDLE & start_i).
- state_o  out  3  current FSM state encoding (see Behaviour).
- pc_we_o  out  1  PC += 4 this edge; valid in WAIT_READY only.
- inst_we_o  out  1  capture read data into the instruction register this edge.
- inst_i  in  32  latched instruction, fed back from the instruction register.
- arvalid_o  out  1  read-address valid to instruction memory (address = PC, external).
- arready_i  in  1  read-address ready.
- rvalid_i  in  1  read-data valid.
- rresp_i  in  2  read response; 2'b00 = OKAY, anything else is an error.
- rready_o  out  1  read-data ready.
- valid_o  out  1  instruction valid to decode.
- ready_i  in  1  decode ready.
- branch_valid_i  in  1  execute has resolved the pending control-flow instruction.
- halt_o  out  1  sticky; ebreak reached.
- err_o  out  1  sticky; memory error or timeout.
- fetch_cnt_o  out  CNT_W  instructions fetched.
- stall_cnt_o  out  CNT_W  decode/branch stall cycles.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - All counters, timeout count, halt_o and err_o cleared.
  - All outputs 0.
  - Reset mid-transaction abandons it; a late rvalid_i after reset is ignored (FSM is in IDLE).
- State encoding:
  - IDLE 3'b000, WAIT_READY 3'b001, DATA 3'b010, ADDR 3'b110, WAIT_BRANCH 3'b100, ERR 3'b101, HALT 3'b111.
  - WAIT_READY (001) and WAIT_BRANCH (100) must keep exactly these codes; the PC register decodes them.
- IDLE:
  - start_i=1 → firing_o=1 this cycle; next state ADDR.
- ADDR:
  - arvalid_o=1.
  - arready_i=1 → DATA.
- DATA:
  - rready_o=1.
  - rvalid_i & rresp_i==0 → inst_we_o=1 (same cycle); fetch_cnt += 1; next WAIT_READY.
  - rvalid_i & rresp_i!=0 → err_o=1; next ERR; inst_we_o stays 0.
- Timeout:
  - A counter is cleared on entry to ADDR and increments every cycle in ADDR or DATA.
  - When the count equals TIMEOUT with no completion in that cycle → err_o=1, next ERR.
  - A completion in that same cycle wins over the timeout.
- WAIT_READY:
  - valid_o=1.
  - The instruction is predecoded from inst_i.
  - ready_i=0 → stall_cnt += 1; remain.
  - ready_i & ebreak (32'h00100073) → HALT, halt_o=1.
  - ready_i & control-flow (opcode 1101111 jal, 1100111 jalr, 1100011 branch) → WAIT_BRANCH, pc_we_o=0.
  - ready_i & other → pc_we_o=1, next ADDR.
- WAIT_BRANCH:
  - branch_valid_i=0 → stall_cnt += 1.
  - branch_valid_i=1 → next ADDR; the PC updates on the same edge.
- ERR and HALT are terminal until reset; start_i is ignored in both.
- Counters saturate at all-ones; no wrap.
- At most one of firing_o / pc_we_o / inst_we_o is high in any cycle.
- Sustained throughput with zero-wait memory and ready decode: one instruction per 3 cycles (ADDR, DATA, WAIT_READY).

Decomposition:
- defines.v holds:
  - state codes FC_IDLE .. FC_HALT;
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH;
  - INST_EBREAK;
  - the existing RESET_VECTOR.
- Sub-module fetch_predecode (combinational): inst_i → is_ctrl, is_ebreak.

Test Plan:
- Reset, then start_i pulse; memory returns 32'h00000013 with zero wait; ready_i=1 → firing_o high 1 cycle, then states 110, 010, 001; pc_we_o at cycle 4; fetch_cnt_o=1.
- Ready_i held 0 for 5 cycles in WAIT_READY → valid_o stays 1; stall_cnt_o=5; no pc_we_o; state stays 3'b001.
- Fetch 32'h0000006F (jal); branch_valid_i asserted after 3 cycles → state 3'b100 for 4 cycles; pc_we_o never asserted; stall_cnt_o=3; then ADDR.
- arready_i never asserted with TIMEOUT=4 → err_o=1 after 4 cycles in ADDR; state 3'b101; start_i ignored.
- rresp_i=2'b10 on rvalid_i → inst_we_o=0, err_o=1, ERR.
- Fetch 32'h00100073 accepted by decode → halt_o=1, state 3'b111; asserting reset mid-DATA returns all outputs to 0 asynchronously.
